// File: rtl/resp_pkg.sv
// Shared definitions for the slave response transmitter: default width,
// output-stage state encoding and the level-width helper.
package resp_pkg;

  localparam int RESP_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } resp_state_e;

  // Level counts the FIFO plus the output register, so 0..DEPTH+1 must fit.
  function automatic int resp_level_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO (DEPTH x DATA_W, DEPTH a power of two) with an extra pointer
// bit so that count can tell full from empty.
module resp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rdata,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);

endmodule

// File: rtl/slave_resp_tx.sv
// Slave-to-master response transmitter: FIFO plus output register driving a
// valid/ready link. Optional registered even parity with macro RESP_PARITY_EN.
module slave_resp_tx
  import resp_pkg::*;
#(
  parameter int DATA_W = RESP_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                            sys_clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            full,
  output logic                            overflow,
  output logic [resp_level_w(DEPTH)-1:0]  level,
  input  logic                            resp_ready,
  output logic                            resp_vaild,
`ifdef RESP_PARITY_EN
  output logic                            resp_parity,
`endif
  output logic [DATA_W-1:0]               resp_data
);

  localparam int LVL_W = resp_level_w(DEPTH);

  resp_state_e          state_q, state_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 overflow_q;
  logic                 fifo_empty;
  logic [DATA_W-1:0]    fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic                 xfer, push_ok, out_free, load, fifo_pop, fifo_push;

  assign full     = (level == LVL_W'(DEPTH + 1));
  assign xfer     = (state_q == VALID) && resp_ready;
  assign push_ok  = wr_en && !full;
  assign out_free = (state_q == IDLE) || xfer;
  assign fifo_pop = out_free && !fifo_empty;
  assign load     = fifo_pop || (out_free && push_ok);
  // Bypass straight into the output register only when nothing is queued ahead.
  assign fifo_push = push_ok && !(out_free && fifo_empty);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = VALID;
      data_d  = fifo_empty ? wr_data : fifo_rdata;
    end else if (xfer) begin
      state_d = IDLE;
    end
  end

  resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (reset),
    .push  (fifo_push),
    .wdata (wr_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

`ifdef RESP_PARITY_EN
  logic parity_q;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      overflow_q <= 1'b0;
`ifdef RESP_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (wr_en && full) overflow_q <= 1'b1;
`ifdef RESP_PARITY_EN
      if (load) parity_q <= ^data_d;
`endif
    end
  end

`ifdef RESP_PARITY_EN
  assign resp_parity = parity_q;
`endif

  assign resp_vaild = (state_q == VALID);
  assign resp_data  = data_q;
  assign overflow   = overflow_q;
  assign level      = LVL_W'(fifo_cnt) + LVL_W'(state_q == VALID);

endmodule

// File: tb/tb_slave_resp_tx.sv
// Directed self-checking bench for slave_resp_tx (default DATA_W=8, DEPTH=4);
// parity checks compile in when RESP_PARITY_EN is defined.
module tb_slave_resp_tx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH + 2);

  logic              sys_clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              overflow;
  logic [LW-1:0]     level;
  logic              resp_ready;
  logic              resp_vaild;
  logic [DATA_W-1:0] resp_data;
`ifdef RESP_PARITY_EN
  logic              resp_parity;
`endif

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] mq[$];

  always #5 sys_clk = ~sys_clk;

  slave_resp_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .overflow    (overflow),
    .level       (level),
    .resp_ready  (resp_ready),
    .resp_vaild  (resp_vaild),
`ifdef RESP_PARITY_EN
    .resp_parity (resp_parity),
`endif
    .resp_data   (resp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [DATA_W-1:0] d, input logic r);
    wr_en      = w;
    wr_data    = d;
    resp_ready = r;
  endtask

  // Reference queue: head is the word on resp_data, size is the level.
  task automatic mcyc(input logic w, input logic [DATA_W-1:0] d, input logic r);
    int sz;
    drive(w, d, r);
    sz = mq.size();
    if (r && sz > 0) void'(mq.pop_front());
    if (w && sz < DEPTH + 1) mq.push_back(d);
    step();
    chk("m_vld",   resp_vaild, (mq.size() > 0));
    chk("m_level", level, mq.size());
    chk("m_full",  full, (mq.size() == DEPTH + 1));
    if (mq.size() > 0) chk("m_data", resp_data, mq[0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] v;
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    #200;
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    step();
    chk("rst_vld",  resp_vaild, 1'b0);
    chk("rst_lvl",  level, 0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf",  overflow, 1'b0);
    chk("rst_data", resp_data, 8'h00);
`ifdef RESP_PARITY_EN
    chk("rst_par",  resp_parity, 1'b0);
`endif

    // Single word with ready high
    drive(1'b1, 8'hA5, 1'b1);
    step();
    chk("one_vld",  resp_vaild, 1'b1);
    chk("one_data", resp_data, 8'hA5);
    chk("one_lvl",  level, 1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("one_vld0", resp_vaild, 1'b0);
    chk("one_lvl0", level, 0);

    // Fill under backpressure, then one dropped push
    for (int i = 1; i <= 5; i++) begin
      v = 8'(i);
      drive(1'b1, v, 1'b0);
      step();
      chk("fill_lvl", level, i);
      chk("fill_data", resp_data, 8'h01);
    end
    chk("fill_full", full, 1'b1);
    chk("fill_ovf0", overflow, 1'b0);
    drive(1'b1, 8'h06, 1'b0);
    step();
    chk("drop_lvl",  level, 5);
    chk("drop_ovf",  overflow, 1'b1);
    chk("drop_data", resp_data, 8'h01);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      step();
      v = 8'(i);
      chk("drain_vld",  resp_vaild, 1'b1);
      chk("drain_data", resp_data, v);
      chk("drain_lvl",  level, 6 - i);
    end
    chk("drain_full0", full, 1'b0);
    step();
    chk("drain_end",  resp_vaild, 1'b0);
    chk("drain_lvl0", level, 0);
    chk("ovf_sticky", overflow, 1'b1);

    // Ready toggling while pushing every cycle
    mq.delete();
    for (int i = 0; i < 16; i++) begin
      v = 8'h10 + 8'(i);
      mcyc(1'b1, v, (i % 2) == 0);
    end
    for (int k = 0; k < 8; k++) mcyc(1'b0, 8'h00, 1'b1);
    chk("tog_empty", resp_vaild, 1'b0);

    // Full-rate streaming with bypass
    for (int i = 0; i < 4; i++) begin
      v = 8'h20 + 8'(i);
      drive(1'b1, v, 1'b1);
      step();
      chk("str_vld",  resp_vaild, 1'b1);
      chk("str_data", resp_data, v);
      chk("str_lvl",  level, 1);
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("str_end", resp_vaild, 1'b0);

    // Asynchronous reset with words in flight
    for (int i = 0; i < 3; i++) begin
      v = 8'h30 + 8'(i);
      drive(1'b1, v, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_lvl", level, 3);
    chk("pre_vld", resp_vaild, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_vld",  resp_vaild, 1'b0);
    chk("arst_lvl",  level, 0);
    chk("arst_data", resp_data, 8'h00);
    chk("arst_ovf",  overflow, 1'b0);
    step();
    step();
    reset = 1'b0;
    drive(1'b1, 8'h77, 1'b0);
    step();
    chk("post_vld",  resp_vaild, 1'b1);
    chk("post_data", resp_data, 8'h77);
    chk("post_lvl",  level, 1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("post_end", resp_vaild, 1'b0);
    chk("post_lvl0", level, 0);

`ifdef RESP_PARITY_EN
    drive(1'b1, 8'h07, 1'b0);
    step();
    chk("par07_data", resp_data, 8'h07);
    chk("par07", resp_parity, 1'b1);
    drive(1'b1, 8'h03, 1'b0);
    step();
    chk("par07_hold", resp_parity, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("par03_data", resp_data, 8'h03);
    chk("par03", resp_parity, 1'b0);
    step();
    chk("par_end", resp_vaild, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
